// File: rtl/airi5c_timer_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : airi5c_timer_sched_pkg
//  Purpose  : Shared constants for the deadline scheduler: per-channel word
//             offsets, CTRL bit positions and the scan FSM state encoding.
//  Ports    : none (package)
//  Config   : none
//  Revision : 1.0 - initial release
// ============================================================================
package airi5c_timer_sched_pkg;

    // Word offsets inside one channel's 4-word register window
    localparam logic [1:0] WORD_DL_LO  = 2'd0;
    localparam logic [1:0] WORD_DL_HI  = 2'd1;
    localparam logic [1:0] WORD_PERIOD = 2'd2;
    localparam logic [1:0] WORD_CTRL   = 2'd3;

    // CTRL register bit positions
    localparam int CTRL_EN   = 0;
    localparam int CTRL_PEND = 1;

    // Scan FSM: SCAN visits one channel per cycle, COMMIT publishes the minimum
    typedef enum logic [0:0] {
        ST_SCAN   = 1'b0,
        ST_COMMIT = 1'b1
    } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/airi5c_timer_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : airi5c_timer_sched_if
//  Purpose  : Register bus between a host and the deadline scheduler.
//  Signals  : wr_en/wr_addr/wr_data - write strobe, {ch, word} address, data
//             rd_en/rd_addr         - read strobe and {ch, word} address
//             rd_data               - registered read data (1 cycle latency)
//  Modports : master (host side), slave (scheduler side)
//  Revision : 1.0 - initial release
// ============================================================================
interface airi5c_timer_sched_if #(
    parameter int CH_W = 2
);
    logic              wr_en;
    logic [CH_W+1:0]   wr_addr;
    logic [31:0]       wr_data;
    logic              rd_en;
    logic [CH_W+1:0]   rd_addr;
    logic [31:0]       rd_data;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data
    );
endinterface
`default_nettype wire

// File: rtl/airi5c_timer_sched_chan.sv
`default_nettype none
// ============================================================================
//  Module   : airi5c_timer_sched_chan
//  Purpose  : One deadline channel: DL_LO shadow, committed 64-bit deadline,
//             optional PERIOD, CTRL {PEND, EN}, write decode and reload adder.
//  Ports    : clk, reset       - clock, synchronous active-high reset
//             wr_sel_i         - bus write addressed to this channel
//             wr_word_i        - word offset of the write
//             wr_data_i        - write data
//             fire_i           - this channel's deadline was reached this cycle
//             dl_o, period_o   - committed deadline, period (0 when absent)
//             en_o, pend_o     - CTRL bits
//             armed_o          - EN && !PEND, candidate for the scan
//  Config   : AIRI5C_TIMER_SCHED_PERIODIC_EN - PERIOD register and reload
//  Revision : 1.0 - initial release
// ============================================================================
module airi5c_timer_sched_chan
    import airi5c_timer_sched_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_sel_i,
    input  logic [1:0]  wr_word_i,
    input  logic [31:0] wr_data_i,
    input  logic        fire_i,
    output logic [63:0] dl_o,
    output logic [31:0] period_o,
    output logic        en_o,
    output logic        pend_o,
    output logic        armed_o
);

    logic [31:0] shadow_q;
    logic [63:0] dl_q, dl_d;
    logic        en_q, en_d;
    logic        pend_q, pend_d;
    logic [31:0] w_period;

`ifdef AIRI5C_TIMER_SCHED_PERIODIC_EN
    logic [31:0] period_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            period_q <= '0;
        end else if (wr_sel_i && (wr_word_i == WORD_PERIOD)) begin
            period_q <= wr_data_i;
        end
    end

    assign w_period = period_q;
`else
    // One-shot build: no period storage, every fire disables the channel
    assign w_period = '0;
`endif

    // Fire effects first, then the bus write overrides the field it targets.
    // PEND set by a fire wins over a simultaneous W1C.
    always_comb begin
        dl_d   = dl_q;
        en_d   = en_q;
        pend_d = pend_q;

        if (fire_i) begin
            pend_d = 1'b1;
            if (w_period != 32'd0) begin
                dl_d = dl_q + {32'd0, w_period};
            end else begin
                en_d = 1'b0;
            end
        end

        if (wr_sel_i) begin
            case (wr_word_i)
                WORD_DL_HI: dl_d = {wr_data_i, shadow_q};
                WORD_CTRL: begin
                    en_d = wr_data_i[CTRL_EN];
                    if (wr_data_i[CTRL_PEND] && !fire_i) begin
                        pend_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= '0;
            dl_q     <= '0;
            en_q     <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            if (wr_sel_i && (wr_word_i == WORD_DL_LO)) begin
                shadow_q <= wr_data_i;
            end
            dl_q   <= dl_d;
            en_q   <= en_d;
            pend_q <= pend_d;
        end
    end

    assign dl_o     = dl_q;
    assign period_o = w_period;
    assign en_o     = en_q;
    assign pend_o   = pend_q;
    assign armed_o  = en_q & ~pend_q;

endmodule
`default_nettype wire

// File: rtl/airi5c_timer_sched.sv
`default_nettype none
// ============================================================================
//  Module   : airi5c_timer_sched
//  Purpose  : Multiplexes NUM_CH deadline channels onto one 64-bit time base.
//             A sequential scan finds the earliest armed deadline, commits it,
//             and raises the owning channel's pending flag once time reaches it.
//  Ports    : clk, reset  - clock, synchronous active-high reset
//             time_i      - current mtime value
//             bus         - register bus (slave modport)
//             irq_o       - per-channel PEND flags, irq_any - OR of irq_o
//             next_cmp    - committed earliest deadline, next_ch - its owner
//             next_vld    - next_cmp is valid and armed
//  Config   : AIRI5C_TIMER_SCHED_PERIODIC_EN - periodic reload (default: one-shot)
//  Revision : 1.0 - initial release
// ============================================================================
module airi5c_timer_sched
    import airi5c_timer_sched_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [63:0]         time_i,
    airi5c_timer_sched_if.slave bus,
    output logic [NUM_CH-1:0]   irq_o,
    output logic                irq_any,
    output logic [63:0]         next_cmp,
    output logic [CH_W-1:0]     next_ch,
    output logic                next_vld
);

    logic [63:0]       w_dl     [NUM_CH];
    logic [31:0]       w_period [NUM_CH];
    logic [NUM_CH-1:0] w_en, w_pend, w_armed, w_wr_sel, w_fire_ch;

    logic [CH_W-1:0]   w_wr_ch, w_rd_ch;
    logic [1:0]        w_wr_word, w_rd_word;
    logic              w_fire;
    logic [31:0]       w_rd_data;

    sched_state_e      state_q;
    logic [CH_W-1:0]   idx_q;
    logic [63:0]       min_q;
    logic [CH_W-1:0]   min_ch_q;
    logic              min_vld_q;
    logic [63:0]       next_cmp_q;
    logic [CH_W-1:0]   next_ch_q;
    logic              next_vld_q;
    logic [31:0]       rd_data_q;

    assign w_wr_ch   = bus.wr_addr[CH_W+1:2];
    assign w_wr_word = bus.wr_addr[1:0];
    assign w_rd_ch   = bus.rd_addr[CH_W+1:2];
    assign w_rd_word = bus.rd_addr[1:0];

    // Unsigned 64-bit compare against the committed deadline
    assign w_fire = next_vld_q && (time_i >= next_cmp_q);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        assign w_wr_sel[i]  = bus.wr_en && (w_wr_ch == CH_W'(i));
        assign w_fire_ch[i] = w_fire && (next_ch_q == CH_W'(i));

        airi5c_timer_sched_chan u_chan (
            .clk       (clk),
            .reset     (reset),
            .wr_sel_i  (w_wr_sel[i]),
            .wr_word_i (w_wr_word),
            .wr_data_i (bus.wr_data),
            .fire_i    (w_fire_ch[i]),
            .dl_o      (w_dl[i]),
            .period_o  (w_period[i]),
            .en_o      (w_en[i]),
            .pend_o    (w_pend[i]),
            .armed_o   (w_armed[i])
        );
    end

    // Scan FSM. Any write or fire invalidates the committed deadline and
    // restarts the scan, so a stale value can never fire.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_SCAN;
            idx_q      <= '0;
            min_q      <= '0;
            min_ch_q   <= '0;
            min_vld_q  <= 1'b0;
            next_cmp_q <= '0;
            next_ch_q  <= '0;
            next_vld_q <= 1'b0;
        end else if (w_fire || bus.wr_en) begin
            state_q    <= ST_SCAN;
            idx_q      <= '0;
            min_vld_q  <= 1'b0;
            next_vld_q <= 1'b0;
        end else begin
            case (state_q)
                ST_SCAN: begin
                    // Strict less-than keeps the lowest index on a tie
                    if (w_armed[idx_q] && (!min_vld_q || (w_dl[idx_q] < min_q))) begin
                        min_q     <= w_dl[idx_q];
                        min_ch_q  <= idx_q;
                        min_vld_q <= 1'b1;
                    end
                    if (idx_q == CH_W'(NUM_CH - 1)) begin
                        state_q <= ST_COMMIT;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    next_cmp_q <= min_q;
                    next_ch_q  <= min_ch_q;
                    next_vld_q <= min_vld_q;
                    min_vld_q  <= 1'b0;
                    idx_q      <= '0;
                    state_q    <= ST_SCAN;
                end
                default: state_q <= ST_SCAN;
            endcase
        end
    end

    // Read mux; channel indices beyond NUM_CH read as zero
    always_comb begin
        w_rd_data = '0;
        if (int'(w_rd_ch) < NUM_CH) begin
            case (w_rd_word)
                WORD_DL_LO:  w_rd_data = w_dl[w_rd_ch][31:0];
                WORD_DL_HI:  w_rd_data = w_dl[w_rd_ch][63:32];
                WORD_PERIOD: w_rd_data = w_period[w_rd_ch];
                default: begin
                    w_rd_data[CTRL_EN]   = w_en[w_rd_ch];
                    w_rd_data[CTRL_PEND] = w_pend[w_rd_ch];
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (bus.rd_en) begin
            rd_data_q <= w_rd_data;
        end
    end

    assign bus.rd_data = rd_data_q;
    assign irq_o       = w_pend;
    assign irq_any     = |w_pend;
    assign next_cmp    = next_cmp_q;
    assign next_ch     = next_ch_q;
    assign next_vld    = next_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_airi5c_timer_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_airi5c_timer_sched
//  Purpose  : Self-checking bench for airi5c_timer_sched: register table,
//             directed multi-cycle sequences and randomized traffic checked
//             against a settle-to-fixpoint reference model.
//  Config   : follows AIRI5C_TIMER_SCHED_PERIODIC_EN of the build
//  Revision : 1.0 - initial release
// ============================================================================
module tb_airi5c_timer_sched;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
`ifdef AIRI5C_TIMER_SCHED_PERIODIC_EN
    localparam bit PERIODIC = 1'b1;
`else
    localparam bit PERIODIC = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic [63:0]       tm;
    logic [NUM_CH-1:0] irq_o;
    logic              irq_any;
    logic [63:0]       next_cmp;
    logic [CH_W-1:0]   next_ch;
    logic              next_vld;

    int n_checks = 0;
    int n_errors = 0;

    airi5c_timer_sched_if #(.CH_W(CH_W)) bus ();

    airi5c_timer_sched #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .time_i   (tm),
        .bus      (bus),
        .irq_o    (irq_o),
        .irq_any  (irq_any),
        .next_cmp (next_cmp),
        .next_ch  (next_ch),
        .next_vld (next_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // Reference model state (register-level view of each channel)
    logic [63:0] m_dl   [NUM_CH];
    logic [31:0] m_sh   [NUM_CH];
    logic [31:0] m_per  [NUM_CH];
    logic        m_en   [NUM_CH];
    logic        m_pend [NUM_CH];

    typedef struct {
        logic        do_wr;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [3:0]  ra;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        bus.rd_en   = 1'b1;
        bus.rd_addr = a;
        tick();
        bus.rd_en   = 1'b0;
        d = bus.rd_data;
    endtask

    task automatic rd_check(input string name, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check(name, {32'd0, d}, {32'd0, exp});
    endtask

    task automatic wait_vld(input string name);
        int n;
        n = 0;
        while (!next_vld && n < 20) begin
            tick();
            n++;
        end
        check(name, {63'd0, next_vld}, 64'd1);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_dl[i] = '0; m_sh[i] = '0; m_per[i] = '0; m_en[i] = 1'b0; m_pend[i] = 1'b0;
        end
    endtask

    // Write through the DUT and apply the same register semantics to the model
    task automatic mwr(input logic [3:0] a, input logic [31:0] d);
        int c;
        c = int'(a[3:2]);
        wr(a, d);
        case (a[1:0])
            2'd0: m_sh[c] = d;
            2'd1: m_dl[c] = {d, m_sh[c]};
            2'd2: m_per[c] = PERIODIC ? d : 32'd0;
            default: begin
                m_en[c] = d[0];
                if (d[1]) m_pend[c] = 1'b0;
            end
        endcase
    endtask

    // With time held long enough, every armed channel whose deadline has been
    // reached fires exactly once (it then sits pending); the survivor with the
    // smallest deadline (lowest index on tie) is the committed one.
    task automatic model_settle_check(input string tag, input logic [63:0] t);
        logic [NUM_CH-1:0] e_irq;
        logic              e_vld;
        logic [63:0]       e_cmp;
        int                e_ch;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m_en[i] && !m_pend[i] && (m_dl[i] <= t)) begin
                m_pend[i] = 1'b1;
                if (m_per[i] != 0) m_dl[i] = m_dl[i] + 64'(m_per[i]);
                else m_en[i] = 1'b0;
            end
        end
        e_vld = 1'b0; e_cmp = '0; e_ch = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            e_irq[i] = m_pend[i];
            if (m_en[i] && !m_pend[i] && (!e_vld || m_dl[i] < e_cmp)) begin
                e_vld = 1'b1; e_cmp = m_dl[i]; e_ch = i;
            end
        end
        check({tag, "_irq"}, 64'(irq_o), 64'(e_irq));
        check({tag, "_irq_any"}, 64'(irq_any), 64'(|e_irq));
        check({tag, "_vld"}, 64'(next_vld), 64'(e_vld));
        if (e_vld) begin
            check({tag, "_cmp"}, next_cmp, e_cmp);
            check({tag, "_ch"}, 64'(next_ch), 64'(e_ch));
        end
    endtask

    initial begin
        logic [31:0] d;
        int          ch, op, nops;

        reset = 1'b1; tm = '0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_en = 1'b0; bus.rd_addr = '0;

        vecs[0] = '{1'b1, 4'h0, 32'hAAAA_0001, 4'h0, 32'h0};          // shadow only
        vecs[1] = '{1'b1, 4'h1, 32'h0000_0002, 4'h0, 32'hAAAA_0001};  // HI commits LO
        vecs[2] = '{1'b0, 4'h0, 32'h0,         4'h1, 32'h0000_0002};
        vecs[3] = '{1'b1, 4'h2, 32'h0000_0040, 4'h2, PERIODIC ? 32'h40 : 32'h0};
        vecs[4] = '{1'b1, 4'h3, 32'h0000_0003, 4'h3, 32'h1};          // EN, W1C no-op
        vecs[5] = '{1'b1, 4'h7, 32'hFFFF_FFFC, 4'h7, 32'h0};          // only low bits live
        vecs[6] = '{1'b1, 4'h3, 32'h0,         4'h3, 32'h0};
        vecs[7] = '{1'b1, 4'h5, 32'h0000_0077, 4'h5, 32'h77};

        // ---- 1: reset state and all-zero register file
        do_reset();
        check("rst_irq", 64'(irq_o), 64'd0);
        check("rst_irq_any", 64'(irq_any), 64'd0);
        check("rst_vld", 64'(next_vld), 64'd0);
        check("rst_cmp", next_cmp, 64'd0);
        check("rst_ch", 64'(next_ch), 64'd0);
        check("rst_rd_data", 64'(bus.rd_data), 64'd0);
        for (int a = 0; a < 16; a++) rd_check("rst_read", 4'(a), 32'd0);

        // ---- register table
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].do_wr) wr(vecs[i].wa, vecs[i].wd);
            rd_check($sformatf("table_%0d", i), vecs[i].ra, vecs[i].exp);
        end

        // ---- 2: single one-shot deadline on ch1
        do_reset();
        wr(4'h4, 32'd100); wr(4'h5, 32'd0); wr(4'h7, 32'd1);
        wait_vld("t2_vld");
        check("t2_next_ch", 64'(next_ch), 64'd1);
        check("t2_next_cmp", next_cmp, 64'd100);
        tm = 64'd99; tick();
        check("t2_no_fire_99", 64'(irq_o), 64'd0);
        tm = 64'd100;
        check("t2_no_fire_same_cycle", 64'(irq_o), 64'd0);
        tick();
        check("t2_fire", 64'(irq_o), 64'd2);
        check("t2_irq_any", 64'(irq_any), 64'd1);
        check("t2_vld_cleared", 64'(next_vld), 64'd0);
        rd_check("t2_ctrl", 4'h7, 32'h2);

        // ---- 3: tie on 500, lowest index first, then ch2 after W1C
        do_reset();
        wr(4'h0, 32'd500); wr(4'h1, 32'd0); wr(4'h3, 32'd1);
        wr(4'h8, 32'd500); wr(4'h9, 32'd0); wr(4'hB, 32'd1);
        wait_vld("t3_vld");
        check("t3_tie_ch", 64'(next_ch), 64'd0);
        tm = 64'd500; tick();
        check("t3_fire_ch0", 64'(irq_o), 64'd1);
        wr(4'h3, 32'd2);
        wait_vld("t3_vld2");
        check("t3_next_ch2", 64'(next_ch), 64'd2);
        tick();
        check("t3_fire_ch2", 64'(irq_o), 64'd4);

        // ---- 4: wrap-around reload on ch3
        do_reset();
        tm = 64'hFFFF_FFFF_FFFF_FFF0;
        wr(4'hC, 32'hFFFF_FFF0); wr(4'hD, 32'hFFFF_FFFF); wr(4'hE, 32'h20); wr(4'hF, 32'd1);
        wait_vld("t4_vld");
        check("t4_next_ch", 64'(next_ch), 64'd3);
        tick();
        check("t4_fire", 64'(irq_o), 64'd8);
        rd_check("t4_dl_lo", 4'hC, PERIODIC ? 32'h10 : 32'hFFFF_FFF0);
        rd_check("t4_dl_hi", 4'hD, PERIODIC ? 32'h0 : 32'hFFFF_FFFF);
        rd_check("t4_period", 4'hE, PERIODIC ? 32'h20 : 32'h0);
        rd_check("t4_ctrl", 4'hF, PERIODIC ? 32'h3 : 32'h2);

        // ---- 5: rewrite an armed deadline to an earlier, already-past value
        do_reset();
        tm = 64'd200;
        wr(4'h0, 32'd1000); wr(4'h1, 32'd0); wr(4'h3, 32'd1);
        wait_vld("t5_vld");
        check("t5_cmp1000", next_cmp, 64'd1000);
        wr(4'h0, 32'd50); wr(4'h1, 32'd0);
        check("t5_vld_cleared", 64'(next_vld), 64'd0);
        for (int k = 1; k <= NUM_CH + 2; k++) begin
            tick();
            if (k < NUM_CH + 2) check("t5_no_early_fire", 64'(irq_o), 64'd0);
            else                check("t5_fire_latency", 64'(irq_o), 64'd1);
        end
        check("t5_cmp50", next_cmp, 64'd50);

        // ---- 6a: DL_LO shadow alone changes nothing
        do_reset();
        tm = 64'd200;
        wr(4'h0, 32'd1000); wr(4'h1, 32'd0); wr(4'h3, 32'd1);
        wait_vld("t6_vld");
        wr(4'h0, 32'd100);
        tm = 64'd150;
        for (int k = 0; k < 20; k++) tick();
        check("t6_shadow_nofire", 64'(irq_o), 64'd0);
        check("t6_shadow_vld", 64'(next_vld), 64'd1);
        check("t6_shadow_cmp", next_cmp, 64'd1000);
        rd_check("t6_shadow_dl_lo", 4'h0, 32'd1000);

        // ---- 6b: reset mid-scan and mid-fire
        do_reset();
        tm = 64'd20;
        wr(4'h8, 32'd10); wr(4'h9, 32'd0); wr(4'hA, 32'd5); wr(4'hB, 32'd1);
        rd_check("t6_pre_rd", 4'h8, 32'd10);
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        check("t6_midscan_rd", 64'(bus.rd_data), 64'd0);
        check("t6_midscan_vld", 64'(next_vld), 64'd0);
        check("t6_midscan_cmp", next_cmp, 64'd0);
        rd_check("t6_midscan_ctrl", 4'hB, 32'd0);
        wr(4'h8, 32'd10); wr(4'h9, 32'd0); wr(4'hA, 32'd5); wr(4'hB, 32'd1);
        wait_vld("t6_fire_vld");
        reset = 1'b1; tick(); reset = 1'b0;
        check("t6_midfire_irq", 64'(irq_o), 64'd0);
        check("t6_midfire_vld", 64'(next_vld), 64'd0);
        rd_check("t6_midfire_dl", 4'h8, 32'd0);

        // ---- randomized traffic against the reference model
        do_reset();
        for (int it = 0; it < 40; it++) begin
            nops = $urandom_range(1, 4);
            for (int k = 0; k < nops; k++) begin
                ch = $urandom_range(0, NUM_CH - 1);
                op = $urandom_range(0, 4);
                case (op)
                    0: begin
                        mwr({ch[1:0], 2'd0}, 32'($urandom_range(0, 3000)));
                        mwr({ch[1:0], 2'd1}, ($urandom_range(0, 7) == 0) ? 32'd1 : 32'd0);
                    end
                    1: mwr({ch[1:0], 2'd0}, 32'($urandom_range(0, 3000)));
                    2: mwr({ch[1:0], 2'd2}, ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 400)));
                    3: mwr({ch[1:0], 2'd3}, 32'($urandom_range(0, 3)));
                    default: mwr({ch[1:0], 2'd3}, 32'd3);
                endcase
            end
            tm = 64'($urandom_range(0, 3000));
            for (int k = 0; k < 50; k++) tick();
            model_settle_check("rand", tm);
            ch = $urandom_range(0, NUM_CH - 1);
            rd_check("rand_dl_lo", {ch[1:0], 2'd0}, m_dl[ch][31:0]);
            rd_check("rand_dl_hi", {ch[1:0], 2'd1}, m_dl[ch][63:32]);
            rd_check("rand_period", {ch[1:0], 2'd2}, m_per[ch]);
            rd_check("rand_ctrl", {ch[1:0], 2'd3}, {30'd0, m_pend[ch], m_en[ch]});
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
